fetch_unit: RTL

// Instruction fetch stage directly upstream of decode.

---
 rtl/fetch_unit_if.sv | 40 ++++
 rtl/fetch_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the decode handshake.
// The master modport is the fetch unit's view; slave is the memory/decode/controller side.
interface fetch_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redir_i;
    logic [31:0] redir_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_rvalid_i,
        input  imem_rdata_i,
        input  redir_i,
        input  redir_pc_i,
        output instr_valid_o,
        input  instr_ready_i,
        output instr_o,
        output pc_o
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_rvalid_i,
        output imem_rdata_i,
        output redir_i,
        output redir_pc_i,
        input  instr_valid_o,
        output instr_ready_i,
        input  instr_o,
        input  pc_o
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited reads to a 1-cycle memory,
// buffers returned words and presents {instr, pc} to decode; a redirect flushes everything.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         res_i,
    fetch_unit_if.master bus
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CRD_W = CNT_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [31:0]      pc_q,       pc_d;
    logic [31:0]      req_pc_q,   req_pc_d;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [31:0]      instr_mem_q [FIFO_DEPTH];
    logic [31:0]      instr_mem_d [FIFO_DEPTH];
    logic [31:0]      pc_mem_q    [FIFO_DEPTH];
    logic [31:0]      pc_mem_d    [FIFO_DEPTH];

    logic             valid_c;
    logic             pop_c;
    logic             issue_c;
    logic             full_c;
    logic             push_c;
    logic [CRD_W-1:0] credit_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake and issue decisions; reset masks everything visible to the outside.
    always_comb begin
        valid_c  = !res_i && (count_q != '0);
        pop_c    = valid_c && bus.instr_ready_i;
        credit_c = CRD_W'(count_q) + CRD_W'(inflight_q) - CRD_W'(pop_c);
        issue_c  = !res_i && !bus.redir_i && (credit_c < CRD_W'(FIFO_DEPTH));
        full_c   = (count_q == CNT_W'(FIFO_DEPTH));
        // A response with nothing outstanding, or one that would overflow, is dropped.
        push_c   = bus.imem_rvalid_i && inflight_q && !bus.redir_i && !(full_c && !pop_c);
    end

    // Next-state for PC, request tracking and the instruction buffer.
    always_comb begin
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        inflight_d  = 1'b0;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;

        if (bus.redir_i) begin
            pc_d     = bus.redir_pc_i & ~32'h0000_0003;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (issue_c) begin
                pc_d       = pc_q + 32'd4;
                req_pc_d   = pc_q;
                inflight_d = 1'b1;
            end
            if (push_c) begin
                instr_mem_d[wr_ptr_q] = bus.imem_rdata_i;
                pc_mem_d[wr_ptr_q]    = req_pc_q;
                wr_ptr_d              = ptr_inc(wr_ptr_q);
            end
            if (pop_c) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                instr_mem_q[i] <= NOP;
                pc_mem_q[i]    <= 32'h0000_0000;
            end
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            instr_mem_q <= instr_mem_d;
            pc_mem_q    <= pc_mem_d;
        end
    end

    assign bus.imem_req_o    = issue_c;
    assign bus.imem_addr_o   = pc_q;
    assign bus.instr_valid_o = valid_c;
    assign bus.instr_o       = res_i ? NOP : instr_mem_q[rd_ptr_q];
    assign bus.pc_o          = res_i ? 32'h0000_0000 : pc_mem_q[rd_ptr_q];

`ifndef SYNTHESIS
    // Memory protocol errors: orphan responses and overflowing pushes.
    a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (res_i)
        (bus.imem_rvalid_i && !bus.redir_i) |-> inflight_q);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (res_i)
        (bus.imem_rvalid_i && inflight_q && !bus.redir_i) |-> (!full_c || pop_c));
`endif

endmodule
